aes_round_ctrl: RTL and testbench

Iterative AES-128 encryption sequencer. Owns the 128-bit state register and the round counter, and applies AddRoundKey (state XOR round key) internally. The SubBytes/ShiftRows/MixColumns round function is an external combinational block, and the round keys come from an external key-schedule unit over a request/valid handshake. It sits between the block-input interface and the ciphertext output of the AES core.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_round_ctrl_if.sv | 39 +++
 rtl/aes_round_fsm.sv | 115 +++++++++++
 rtl/aes_round_ctrl.sv | 92 +++++++++
 tb/tb_aes_round_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_pkg : shared AES sequencer types (block type, FSM states, round count)
// Rev 1.0
// ----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_round_ctrl_if : block-in, key-schedule, round-function and ciphertext bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface aes_round_ctrl_if
  import aes_pkg::*;
#(
  parameter int KIDX_W = 4
);

  logic              in_valid;
  logic              in_ready;
  aes_block_t        in_data;
  logic              key_req;
  logic [KIDX_W-1:0] key_idx;
  logic              key_vld;
  aes_block_t        key_data;
  aes_block_t        rnd_state;
  logic              rnd_last;
  aes_block_t        rnd_res;
  logic              out_valid;
  logic              out_ready;
  aes_block_t        out_data;
  logic              busy;

  // master is the surrounding core, slave is the round controller
  modport master (
    output in_valid, in_data, key_vld, key_data, rnd_res, out_ready,
    input  in_ready, key_req, key_idx, rnd_state, rnd_last, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, key_vld, key_data, rnd_res, out_ready,
    output in_ready, key_req, key_idx, rnd_state, rnd_last, out_valid, out_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/aes_round_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_round_fsm : IDLE/ROUND/DONE sequencer, round counter, handshake decode
// Rev 1.0
// ----------------------------------------------------------------------------
module aes_round_fsm
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KIDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_in_valid,
  input  logic              i_key_vld,
  input  logic              i_out_ready,
  input  logic              i_abort,
  output logic              o_in_ready,
  output logic              o_key_req,
  output logic [KIDX_W-1:0] o_key_idx,
  output logic              o_rnd_last,
  output logic              o_out_valid,
  output logic              o_busy,
  output logic              o_load,
  output logic              o_add_key,
  output logic              o_first,
  output logic              o_clear
);

  localparam logic [KIDX_W-1:0] c_NR      = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] c_RND_ONE = KIDX_W'(1);

  aes_state_e        r_state;
  logic [KIDX_W-1:0] r_rnd;
  logic              r_key_req;
  logic              r_rnd_last;
  logic              r_out_valid;
  logic              r_busy;
  logic [KIDX_W-1:0] w_rnd_inc;

  assign w_rnd_inc   = r_rnd + c_RND_ONE;

  assign o_in_ready  = (r_state == IDLE);
  assign o_key_req   = r_key_req;
  assign o_key_idx   = r_rnd;
  assign o_rnd_last  = r_rnd_last;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;

  // Datapath strobes; abort outranks key_vld so a dying block never updates
  assign o_load      = (r_state == IDLE) && i_in_valid;
  assign o_add_key   = (r_state == ROUND) && i_key_vld && !i_abort;
  assign o_first     = (r_rnd == '0);
  assign o_clear     = i_abort && (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rnd       <= '0;
      r_key_req   <= 1'b0;
      r_rnd_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_state    <= ROUND;
            r_rnd      <= '0;
            r_key_req  <= 1'b1;
            r_rnd_last <= (c_NR == '0);
            r_busy     <= 1'b1;
          end
        end
        ROUND: begin
          if (i_abort) begin
            r_state    <= IDLE;
            r_rnd      <= '0;
            r_key_req  <= 1'b0;
            r_rnd_last <= 1'b0;
            r_busy     <= 1'b0;
          end else if (i_key_vld) begin
            if (r_rnd == c_NR) begin
              r_state     <= DONE;
              r_rnd       <= '0;
              r_key_req   <= 1'b0;
              r_rnd_last  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_rnd      <= w_rnd_inc;
              r_rnd_last <= (w_rnd_inc == c_NR);
            end
          end
        end
        DONE: begin
          if (i_abort || i_out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rnd       <= '0;
          r_key_req   <= 1'b0;
          r_rnd_last  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_round_ctrl : iterative AES-128 sequencer; state register + AddRoundKey.
// Optional abort port when AES_ROUND_CTRL_ABORT_EN is defined.  Rev 1.0
// ----------------------------------------------------------------------------
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int KIDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic            abort,
`endif
  aes_round_ctrl_if.slave bus
);

  logic              w_abort;
  logic              w_in_ready;
  logic              w_key_req;
  logic [KIDX_W-1:0] w_key_idx;
  logic              w_rnd_last;
  logic              w_out_valid;
  logic              w_busy;
  logic              w_load;
  logic              w_add_key;
  logic              w_first;
  logic              w_clear;
  aes_block_t        w_blk_nxt;
  aes_block_t        r_blk;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  aes_round_fsm #(
    .NR     (NR),
    .KIDX_W (KIDX_W)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (bus.in_valid),
    .i_key_vld   (bus.key_vld),
    .i_out_ready (bus.out_ready),
    .i_abort     (w_abort),
    .o_in_ready  (w_in_ready),
    .o_key_req   (w_key_req),
    .o_key_idx   (w_key_idx),
    .o_rnd_last  (w_rnd_last),
    .o_out_valid (w_out_valid),
    .o_busy      (w_busy),
    .o_load      (w_load),
    .o_add_key   (w_add_key),
    .o_first     (w_first),
    .o_clear     (w_clear)
  );

  // Round 0 is the bare initial AddRoundKey; later rounds whiten the round-function result
  always_comb begin
    w_blk_nxt = r_blk;
    if (w_clear) begin
      w_blk_nxt = '0;
    end else if (w_load) begin
      w_blk_nxt = bus.in_data;
    end else if (w_add_key) begin
      w_blk_nxt = (w_first ? r_blk : bus.rnd_res) ^ bus.key_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk <= '0;
    end else begin
      r_blk <= w_blk_nxt;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.key_req   = w_key_req;
  assign bus.key_idx   = w_key_idx;
  assign bus.rnd_state = r_blk;
  assign bus.rnd_last  = w_rnd_last;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_blk;
  assign bus.busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_round_ctrl : directed FIPS-197 vectors with a behavioural round
// function and key schedule around the sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int         NR     = AES_NR;
  localparam int         KIDX_W = 4;
  localparam aes_block_t c_PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam aes_block_t c_KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t c_CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam aes_block_t c_CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;
  aes_block_t round_keys [16];

  aes_round_ctrl_if #(.KIDX_W(KIDX_W)) bus ();
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  aes_round_ctrl #(
    .NR     (NR),
    .KIDX_W (KIDX_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: a^254 is the GF(2^8) inverse, then the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = 8'h00;
    if (a != 8'h00) begin
      b = a;
      for (int i = 0; i < 253; i++) b = gmul(b, a);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_block_t aes_round(input aes_block_t s, input logic last);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [7:0] m [16];
    aes_block_t r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr+4*c] = a[rr+4*((c+rr)%4)];
    for (int c = 0; c < 4; c++) begin
      m[4*c+0] = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
      m[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
      m[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
      m[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? t[i] : m[i];
    return r;
  endfunction

  task automatic expand_key(input aes_block_t k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      round_keys[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  assign bus.rnd_res  = aes_round(bus.rnd_state, bus.rnd_last);
  assign bus.key_data = round_keys[bus.key_idx];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input aes_block_t pt);
    bus.in_data  = pt;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.key_req !== 1'b0) begin n_fail++; $display("FAIL reset_key_req: got %b want 0", bus.key_req); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.key_idx !== '0) begin n_fail++; $display("FAIL reset_key_idx: got %0d want 0", bus.key_idx); end
    n_checks++; if (bus.rnd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rnd_last: got %b want 0", bus.rnd_last); end
    @(negedge clk) rst = 1'b0;
    tick();
  endtask

  task automatic test_fips();
    int lat;
    lat = 0;
    expand_key(c_KEY1);
    bus.key_vld = 1'b1;
    accept(c_PT1);
    n_checks++; if (bus.key_req !== 1'b1) begin n_fail++; $display("FAIL fips_key_req_e1: got %b want 1", bus.key_req); end
    n_checks++; if (bus.key_idx !== '0) begin n_fail++; $display("FAIL fips_key_idx_e1: got %0d want 0", bus.key_idx); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fips_in_ready_busy: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fips_busy: got %b want 1", bus.busy); end
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.out_valid === 1'b1) begin lat = c; break; end
    end
    bus.key_vld = 1'b0;
    n_checks++; if (lat != NR + 1) begin n_fail++; $display("FAIL fips_latency: got %0d want %0d", lat, NR + 1); end
    n_checks++; if (bus.out_data !== c_CT1) begin n_fail++; $display("FAIL fips_ct: got %h want %h", bus.out_data, c_CT1); end
    n_checks++; if (bus.key_req !== 1'b0) begin n_fail++; $display("FAIL fips_key_req_done: got %b want 0", bus.key_req); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fips_out_valid_drop: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fips_in_ready_back: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fips_busy_idle: got %b want 0", bus.busy); end
  endtask

  task automatic test_stall();
    int s;
    expand_key(c_KEY1);
    bus.key_vld = 1'b0;
    accept(c_PT1);
    for (int idx = 0; idx <= NR; idx++) begin
      s = int'($urandom_range(5, 0));
      bus.key_vld = 1'b0;
      for (int w = 0; w <= s; w++) begin
        if (w > 0) tick();
        n_checks++; if (bus.key_req !== 1'b1) begin n_fail++; $display("FAIL stall_key_req: idx %0d got %b want 1", idx, bus.key_req); end
        n_checks++; if (bus.key_idx !== KIDX_W'(idx)) begin n_fail++; $display("FAIL stall_key_idx: got %0d want %0d", bus.key_idx, idx); end
        n_checks++; if (bus.rnd_last !== (idx == NR)) begin n_fail++; $display("FAIL stall_rnd_last: idx %0d got %b want %b", idx, bus.rnd_last, idx == NR); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_early_valid: idx %0d got %b want 0", idx, bus.out_valid); end
      end
      bus.key_vld = 1'b1;
      tick();
    end
    bus.key_vld = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid: got %b want 1", bus.out_valid); end
    n_checks++; if (bus.out_data !== c_CT1) begin n_fail++; $display("FAIL stall_ct: got %h want %h", bus.out_data, c_CT1); end
  endtask

  task automatic test_hold_done();
    for (int i = 0; i < 20; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid: cyc %0d got %b want 1", i, bus.out_valid); end
      n_checks++; if (bus.out_data !== c_CT1) begin n_fail++; $display("FAIL hold_out_data: cyc %0d got %h want %h", i, bus.out_data, c_CT1); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready: cyc %0d got %b want 0", i, bus.in_ready); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_in_ready: got %b want 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_out_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_ignore();
    expand_key(c_KEY1);
    bus.key_vld = 1'b1;
    accept(c_PT1);
    repeat (NR + 1) tick();
    bus.key_vld = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ign_reach_done: got %b want 1", bus.out_valid); end
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = i[0];
      bus.in_data  = ~c_PT1;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL ign_done_state: got valid %b busy %b want 1 1", bus.out_valid, bus.busy); end
      n_checks++; if (bus.out_data !== c_CT1) begin n_fail++; $display("FAIL ign_done_data: got %h want %h", bus.out_data, c_CT1); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.key_vld = i[0];
      tick();
      n_checks++; if (bus.busy !== 1'b0 || bus.key_req !== 1'b0) begin n_fail++; $display("FAIL ign_idle_ctrl: got busy %b key_req %b want 0 0", bus.busy, bus.key_req); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ign_idle_in_ready: got %b want 1", bus.in_ready); end
      n_checks++; if (bus.out_data !== c_CT1) begin n_fail++; $display("FAIL ign_idle_state: got %h want %h", bus.out_data, c_CT1); end
    end
    bus.key_vld = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    lat = 0;
    expand_key(c_KEY1);
    bus.key_vld = 1'b1;
    accept(c_PT1);
    repeat (5) tick();
    n_checks++; if (bus.key_idx !== KIDX_W'(5)) begin n_fail++; $display("FAIL rmid_pre_idx: got %0d want 5", bus.key_idx); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.key_req !== 1'b0) begin n_fail++; $display("FAIL rmid_async_ctrl: got busy %b key_req %b want 0 0", bus.busy, bus.key_req); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async_hs: got in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL rmid_async_data: got %h want 0", bus.out_data); end
    n_checks++; if (bus.key_idx !== '0 || bus.rnd_last !== 1'b0) begin n_fail++; $display("FAIL rmid_async_idx: got idx %0d last %b want 0 0", bus.key_idx, bus.rnd_last); end
    @(negedge clk) rst = 1'b0;
    expand_key('0);
    accept('0);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.out_valid === 1'b1) begin lat = c; break; end
    end
    bus.key_vld = 1'b0;
    n_checks++; if (lat != NR + 1) begin n_fail++; $display("FAIL rmid_latency: got %0d want %0d", lat, NR + 1); end
    n_checks++; if (bus.out_data !== c_CT0) begin n_fail++; $display("FAIL rmid_ct0: got %h want %h", bus.out_data, c_CT0); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
  task automatic test_abort();
    int lat;
    lat = 0;
    expand_key(c_KEY1);
    bus.key_vld = 1'b0;
    accept(c_PT1);
    bus.key_vld = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.key_idx !== KIDX_W'(3)) begin n_fail++; $display("FAIL abort_pre_idx: got %0d want 3", bus.key_idx); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    bus.key_vld = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got busy %b in_ready %b want 0 1", bus.busy, bus.in_ready); end
    n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL abort_state_zero: got %h want 0", bus.out_data); end
    n_checks++; if (bus.key_req !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_outputs: got key_req %b out_valid %b want 0 0", bus.key_req, bus.out_valid); end
    repeat (3) tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b want 0", bus.out_valid); end
    bus.key_vld = 1'b1;
    abort = 1'b1;
    accept(c_PT1);
    abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL abort_idle_ignored: got busy %b want 1", bus.busy); end
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.out_valid === 1'b1) begin lat = c; break; end
    end
    bus.key_vld = 1'b0;
    n_checks++; if (lat != NR + 1) begin n_fail++; $display("FAIL abort_next_latency: got %0d want %0d", lat, NR + 1); end
    n_checks++; if (bus.out_data !== c_CT1) begin n_fail++; $display("FAIL abort_next_ct: got %h want %h", bus.out_data, c_CT1); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.key_vld   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_fips();
    test_stall();
    test_hold_done();
    test_ignore();
    test_reset_mid();
`ifdef AES_ROUND_CTRL_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
